// File: rtl/pc_next_unit.sv
// Next-PC generator: RUN/HALT sequencer plus return-address stack feeding the PC register.
// The return-address stack is built only when PCNU_RAS_EN is defined; otherwise call acts as jmp and ret flags an error.
module pc_next_unit #(
    parameter int ADDR_W    = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_pc_cur,
    input  logic              i_stall,
    input  logic              i_br_taken,
    input  logic              i_jmp,
    input  logic              i_call,
    input  logic              i_ret,
    input  logic [ADDR_W-1:0] i_tgt,
    input  logic              i_halt_req,
    input  logic              i_resume,
    output logic [ADDR_W-1:0] o_pc_next,
    output logic              o_halted,
    output logic              o_ras_empty,
    output logic              o_ras_full,
    output logic              o_ras_err
);

    if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_next_unit: RAS_DEPTH must be a power of two in 2..16");
    end

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_halted;
    logic              r_ras_err;
    logic              w_err_set;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_sel;

`ifdef PCNU_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
    logic [PTR_W-1:0]  r_top;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_ras_empty;
    logic              r_ras_full;
    logic              w_push;
    logic              w_pop;
`endif

    // Redirection policy: pick the next PC and decide stack/state side effects
    always_comb begin
        w_pc_inc    = i_pc_cur + ADDR_W'(1);
        w_pc_sel    = w_pc_inc;
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
`ifdef PCNU_RAS_EN
        w_push      = 1'b0;
        w_pop       = 1'b0;
`endif
        case (r_state)
            ST_RUN: begin
                if (i_stall) begin
                    w_pc_sel = i_pc_cur;
                end else if (i_halt_req) begin
                    w_pc_sel    = i_pc_cur;
                    w_state_nxt = ST_HALT;
                end else if (i_ret) begin
`ifdef PCNU_RAS_EN
                    if (r_ras_empty) begin
                        w_pc_sel  = w_pc_inc;
                        w_err_set = 1'b1;
                    end else begin
                        w_pc_sel = r_stack[r_top];
                        w_pop    = 1'b1;
                    end
`else
                    w_pc_sel  = w_pc_inc;
                    w_err_set = 1'b1;
`endif
                end else if (i_call) begin
                    w_pc_sel  = i_tgt;
`ifdef PCNU_RAS_EN
                    // A push onto a full stack silently drops the oldest return address
                    w_push    = 1'b1;
                    w_err_set = r_ras_full;
`endif
                end else if (i_jmp || i_br_taken) begin
                    w_pc_sel = i_tgt;
                end else begin
                    w_pc_sel = w_pc_inc;
                end
            end
            ST_HALT: begin
                w_pc_sel = i_pc_cur;
                if (i_resume) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
                w_pc_sel    = i_pc_cur;
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // PC output is forced to zero while reset is held so the PC register loads address 0
    always_comb begin
        if (!i_rst_n) begin
            o_pc_next = {ADDR_W{1'b0}};
        end else begin
            o_pc_next = w_pc_sel;
        end
    end

    // Sequencer state, halted flag and sticky stack error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_RUN;
            r_halted  <= 1'b0;
            r_ras_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_halted  <= (w_state_nxt == ST_HALT);
            r_ras_err <= r_ras_err | w_err_set;
        end
    end

`ifdef PCNU_RAS_EN
    // Occupancy after this cycle's push/pop; saturates at full
    always_comb begin
        if (w_push && !r_ras_full) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (w_pop) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Circular stack storage: r_top indexes the newest entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_stack[i] <= {ADDR_W{1'b0}};
            end
            r_top       <= {PTR_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_ras_empty <= 1'b1;
            r_ras_full  <= 1'b0;
        end else begin
            if (w_push) begin
                r_stack[r_top + PTR_W'(1)] <= w_pc_inc;
                r_top                      <= r_top + PTR_W'(1);
            end else if (w_pop) begin
                r_top <= r_top - PTR_W'(1);
            end else begin
                r_top <= r_top;
            end
            r_cnt       <= w_cnt_nxt;
            r_ras_empty <= (w_cnt_nxt == {CNT_W{1'b0}});
            r_ras_full  <= (w_cnt_nxt == CNT_FULL);
        end
    end

    assign o_ras_empty = r_ras_empty;
    assign o_ras_full  = r_ras_full;
`else
    assign o_ras_empty = 1'b1;
    assign o_ras_full  = 1'b0;
`endif

    assign o_halted  = r_halted;
    assign o_ras_err = r_ras_err;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: a queue-based reference model predicts every cycle's outputs.
module tb_pc_next_unit;

    localparam int ADDR_W    = 8;
    localparam int RAS_DEPTH = 4;

    typedef struct packed {
        logic [7:0] pc;
        logic       halted;
        logic       empty;
        logic       full;
        logic       err;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [7:0] i_pc_cur = 8'h00;
    logic       i_stall = 1'b0;
    logic       i_br_taken = 1'b0;
    logic       i_jmp = 1'b0;
    logic       i_call = 1'b0;
    logic       i_ret = 1'b0;
    logic [7:0] i_tgt = 8'h00;
    logic       i_halt_req = 1'b0;
    logic       i_resume = 1'b0;
    logic [7:0] o_pc_next;
    logic       o_halted;
    logic       o_ras_empty;
    logic       o_ras_full;
    logic       o_ras_err;

    int n_checks = 0;
    int n_errors = 0;

    exp_t       sb_q[$];
    logic [7:0] ras_q[$];
    logic [7:0] m_pc = 8'h00;
    logic       m_halted = 1'b0;
    logic       m_err = 1'b0;

    pc_next_unit #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc_cur(i_pc_cur), .i_stall(i_stall),
        .i_br_taken(i_br_taken), .i_jmp(i_jmp), .i_call(i_call), .i_ret(i_ret),
        .i_tgt(i_tgt), .i_halt_req(i_halt_req), .i_resume(i_resume),
        .o_pc_next(o_pc_next), .o_halted(o_halted), .o_ras_empty(o_ras_empty),
        .o_ras_full(o_ras_full), .o_ras_err(o_ras_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic model_empty();
`ifdef PCNU_RAS_EN
        return (ras_q.size() == 0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic model_full();
`ifdef PCNU_RAS_EN
        return (ras_q.size() == RAS_DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: one cycle of the PC redirection rules, then the PC register loads the result
    task automatic model_step(input logic st, br, jp, cl, rt, input logic [7:0] tg, input logic hr, rs);
        exp_t       e;
        logic [7:0] inc;
        logic [7:0] nxt;
        inc      = m_pc + 8'd1;
        e.halted = m_halted;
        e.empty  = model_empty();
        e.full   = model_full();
        e.err    = m_err;
        if (m_halted) begin
            nxt = m_pc;
            if (rs) m_halted = 1'b0;
        end else if (st) begin
            nxt = m_pc;
        end else if (hr) begin
            nxt      = m_pc;
            m_halted = 1'b1;
        end else if (rt) begin
`ifdef PCNU_RAS_EN
            if (ras_q.size() == 0) begin
                nxt   = inc;
                m_err = 1'b1;
            end else begin
                nxt = ras_q.pop_back();
            end
`else
            nxt   = inc;
            m_err = 1'b1;
`endif
        end else if (cl) begin
            nxt = tg;
`ifdef PCNU_RAS_EN
            ras_q.push_back(inc);
            if (ras_q.size() > RAS_DEPTH) begin
                void'(ras_q.pop_front());
                m_err = 1'b1;
            end
`endif
        end else if (jp || br) begin
            nxt = tg;
        end else begin
            nxt = inc;
        end
        e.pc = nxt;
        sb_q.push_back(e);
        m_pc = nxt;
    endtask

    task automatic drive(input logic st, br, jp, cl, rt, input logic [7:0] tg, input logic hr, rs);
        @(posedge i_clk);
        #1;
        i_pc_cur   = m_pc;
        i_stall    = st;
        i_br_taken = br;
        i_jmp      = jp;
        i_call     = cl;
        i_ret      = rt;
        i_tgt      = tg;
        i_halt_req = hr;
        i_resume   = rs;
        model_step(st, br, jp, cl, rt, tg, hr, rs);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc_next"}, o_pc_next, 8'h00);
        chk({tag, "_halted"}, {7'd0, o_halted}, 8'h00);
        chk({tag, "_empty"}, {7'd0, o_ras_empty}, 8'h01);
        chk({tag, "_full"}, {7'd0, o_ras_full}, 8'h00);
        chk({tag, "_err"}, {7'd0, o_ras_err}, 8'h00);
    endtask

    // Monitor: every cycle the DUT presents a PC, compare it against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pc_next", o_pc_next, e.pc);
                chk("halted", {7'd0, o_halted}, {7'd0, e.halted});
                chk("ras_empty", {7'd0, o_ras_empty}, {7'd0, e.empty});
                chk("ras_full", {7'd0, o_ras_full}, {7'd0, e.full});
                chk("ras_err", {7'd0, o_ras_err}, {7'd0, e.err});
            end
        end
    end

    initial begin
        // Reset held with active controls on the inputs
        #1;
        i_pc_cur = 8'h55;
        i_jmp    = 1'b1;
        i_tgt    = 8'h77;
        #2;
        check_reset_outputs("por");
        @(negedge i_clk);
        i_jmp   = 1'b0;
        i_rst_n = 1'b1;

        // Sequential counting and wrap at the top of the address space
        idle(5);
        m_pc = 8'hFD;
        idle(4);

        // Single call/return
        m_pc = 8'h10;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        idle(1);

        // Five nested calls overflow a four-deep stack, then five returns underflow it
        m_pc = 8'h01;
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, m_pc + 8'd1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // Two entries on the stack, then a half-cycle asynchronous reset
        m_pc = 8'h80;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h90, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA0, 1'b0, 1'b0);
        @(posedge i_clk);
        #1;
        i_call  = 1'b0;
        i_jmp   = 1'b1;
        i_tgt   = 8'h66;
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb_q.delete();
        ras_q.delete();
        m_pc     = 8'h00;
        m_halted = 1'b0;
        m_err    = 1'b0;
        @(negedge i_clk);
        i_jmp   = 1'b0;
        i_rst_n = 1'b1;
        idle(2);

        // Stall beats jump; ret beats call
        m_pc = 8'h07;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0);
        m_pc = 8'h21;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h50, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h60, 1'b0, 1'b0);
        idle(1);

        // Halt holds the PC against jumps until resume
        m_pc = 8'h30;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(3);

        // Randomized control mix
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(7) == 0), ($urandom_range(7) == 0), ($urandom_range(7) == 0),
                  ($urandom_range(4) == 0), ($urandom_range(4) == 0), 8'($urandom),
                  ($urandom_range(15) == 0), ($urandom_range(3) == 0));
        end

        @(negedge i_clk);
        #1;
        chk("scoreboard_drained", 8'(sb_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Next-PC generator sitting directly upstream of the 8-bit program-counter register: it takes the current PC value and the decode-stage control pulses and produces the address the PC register loads on the next rising `clk` edge. It holds a small return-address stack (RAS) for call/return and a RUN/HALT sequencer, so all PC redirection policy lives here and the PC register stays a plain load register.

## Interface
- `ADDR_W`, 8, PC/address width in bits
- `RAS_DEPTH`, 4, return-address stack entries (power of two, 2..16)

- `clk`  in  1  rising-edge clock, shared with the PC register
- `rst_n`  in  1  asynchronous active-low reset
- `pc_cur`  in  ADDR_W  current PC register output
- `stall`  in  1  hold PC this cycle
- `br_taken`  in  1  conditional branch resolved taken
- `jmp`  in  1  unconditional jump
- `call`  in  1  subroutine call (push return address, jump)
- `ret`  in  1  subroutine return (pop)
- `tgt`  in  ADDR_W  target for `br_taken`/`jmp`/`call`
- `halt_req`  in  1  enter HALT
- `resume`  in  1  leave HALT
- `pc_next`  out  ADDR_W  value for the PC register input
- `halted`  out  1  sequencer in HALT
- `ras_empty`  out  1  stack holds no entries
- `ras_full`  out  1  stack holds RAS_DEPTH entries
- `ras_err`  out  1  sticky: overflow or underflow occurred

## Operation
- Reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. While `rst_n`=0: `pc_next`=0, state=RUN, `halted`=0, RAS count=0, `ras_empty`=1, `ras_full`=0, `ras_err`=0.
- States: RUN, HALT. RUN→HALT when `halt_req`=1 (and `stall`=0). HALT→RUN when `resume`=1; `halt_req` in HALT ignored. `halted`=1 exactly in HALT.
- `pc_next` selection in RUN, fixed priority: `stall` → `pc_cur`; `ret` → top of RAS (pop); `call` → `tgt` (push `pc_cur+1`); `jmp` → `tgt`; `br_taken` → `tgt`; else `pc_cur+1`.
- In RUN with `halt_req`=1 (no stall): `pc_next`=`pc_cur`, no RAS change, other controls ignored that cycle. In HALT: `pc_next`=`pc_cur`, all controls except `resume` ignored.
- Increment is modulo 2^ADDR_W: `pc_cur`=0xFF → `pc_cur+1`=0x00; same for pushed return address.
- `ret` with RAS empty: `pc_next`=`pc_cur+1`, count stays 0, `ras_err` set.
- `call` with RAS full: oldest entry discarded, new address on top, count stays RAS_DEPTH, `ras_err` set.
- `call` and `ret` same cycle: `ret` wins, `call` ignored (no push).
- `ras_err` clears only on reset.

## Timing
- `pc_next` is combinational from `pc_cur`, controls, state and RAS top: zero-cycle latency; PC register captures it on the same edge.
- RAS contents/count, state and `ras_err` update on rising `clk`; a push in cycle N is poppable in cycle N+1.
- `halted`, `ras_empty`, `ras_full`, `ras_err` are registered (reflect state after last edge).
- Reset asserted mid-operation clears RAS and state immediately, regardless of `clk`.

## Configuration
- `PCNU_RAS_EN` defined: RAS present as described.
- Undefined: no stack storage; `call` behaves as `jmp` (no push); `ret` treated as no control (`pc_next`=`pc_cur+1`) and sets `ras_err`; `ras_empty`=1, `ras_full`=0 constant.

## Test plan
- Reset then idle: `pc_cur` follows `pc_next` through a PC register model → 0x00,0x01,0x02…; at 0xFF next is 0x00.
- `call` at `pc_cur`=0x10, `tgt`=0x40 → `pc_next`=0x40; later `ret` → `pc_next`=0x11, `ras_empty`=1 after edge.
- Five nested calls from 0x01..0x05 (RAS_DEPTH=4) → `ras_full`=1, `ras_err`=1; four `ret`s return 0x06,0x05,0x04,0x03; fifth `ret` gives `pc_cur+1`.
- `stall`+`jmp` same cycle → `pc_next`=`pc_cur`; `call`+`ret` with top=0x22 → `pc_next`=0x22, count decremented by one.
- `halt_req` at 0x30 → `halted`=1, `pc_next`=0x30 for 5 cycles despite `jmp`; `resume` → next cycle counts 0x31.
- `rst_n` low for a half-cycle with 2 entries on RAS → `pc_next`=0, `ras_empty`=1, `ras_err`=0 immediately.
